// File: rtl/conv_result_streamer.sv
// Captures the convolution core's Z-write results into a buffer, then streams
// them in address order over a valid/ready handshake with a last-beat marker.
module conv_result_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    writeZ_in,
  input  logic [2*DATA_WIDTH-1:0] dataZ_in,
  input  logic [ADDR_WIDTH:0]     memZ_addr_in,
  input  logic                    core_done_in,
  output logic [2*DATA_WIDTH-1:0] m_data_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_in,
  output logic                    m_last_o,
  output logic [ADDR_WIDTH:0]     m_index_o,
  output logic [ADDR_WIDTH+1:0]   result_len_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    overrun_o
);
  localparam int WORD_W = 2 * DATA_WIDTH;
  localparam int PTR_W  = ADDR_WIDTH + 1;
  localparam int LEN_W  = ADDR_WIDTH + 2;
  localparam int DEPTH  = 1 << PTR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_PREFETCH,
    S_STREAM,
    S_FINISH
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rd_data;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  w_ptr_next;
  logic [PTR_W-1:0]  w_rd_addr;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  w_len_next;
  logic [LEN_W-1:0]  w_wr_len;
  logic              r_overrun;
  logic              w_overrun_next;
  logic              w_we;
  logic              w_streaming;
  logic              w_accept;
  logic              w_last;

  // Length implied by a write, widened so address 63 yields 64 without wrapping.
  assign w_wr_len    = {1'b0, memZ_addr_in} + LEN_W'(1);
  assign w_streaming = (r_state == S_STREAM);
  assign w_accept    = w_streaming && m_ready_in;
  assign w_last      = w_streaming && ({1'b0, r_ptr} == (r_len - LEN_W'(1)));

  always_comb begin
    w_state_next   = r_state;
    w_ptr_next     = r_ptr;
    w_len_next     = r_len;
    w_overrun_next = r_overrun;
    w_we           = 1'b0;
    w_rd_addr      = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (writeZ_in) begin
          w_we         = 1'b1;
          w_len_next   = w_wr_len;
          w_state_next = core_done_in ? S_PREFETCH : S_CAPTURE;
        end else if (core_done_in) begin
          w_state_next = S_FINISH;
        end
      end
      S_CAPTURE: begin
        if (writeZ_in) begin
          w_we = 1'b1;
          if (w_wr_len > r_len) begin
            w_len_next = w_wr_len;
          end
        end
        if (core_done_in) begin
          w_state_next = (w_len_next == '0) ? S_FINISH : S_PREFETCH;
        end
      end
      S_PREFETCH: begin
        w_rd_addr    = '0;
        w_ptr_next   = '0;
        w_state_next = S_STREAM;
        if (writeZ_in) begin
          w_overrun_next = 1'b1;
        end
      end
      S_STREAM: begin
        if (writeZ_in) begin
          w_overrun_next = 1'b1;
        end
        // Read ahead on acceptance so the next beat is ready with no bubble.
        if (w_accept) begin
          w_rd_addr = r_ptr + PTR_W'(1);
          if (w_last) begin
            w_state_next = S_FINISH;
          end else begin
            w_ptr_next = r_ptr + PTR_W'(1);
          end
        end
      end
      S_FINISH: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_len     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_ptr     <= w_ptr_next;
      r_len     <= w_len_next;
      r_overrun <= w_overrun_next;
    end
  end

  // Result buffer: contents survive reset; read data is registered.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[memZ_addr_in] <= dataZ_in;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  assign m_valid_o    = w_streaming;
  assign m_data_o     = w_streaming ? r_rd_data : '0;
  assign m_index_o    = w_streaming ? r_ptr : '0;
  assign m_last_o     = w_last;
  assign result_len_o = r_len;
  assign busy_o       = (r_state == S_CAPTURE) || (r_state == S_PREFETCH) || w_streaming;
  assign done_o       = (r_state == S_FINISH);
  assign overrun_o    = r_overrun;
endmodule

// File: tb/tb_conv_result_streamer.sv
// Self-checking bench for conv_result_streamer: a phase-level reference model
// is compared every cycle, plus literal expectations for each scenario.
`timescale 1ns/1ps
module tb_conv_result_streamer;
  localparam int WW = 16;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          writeZ_in = 1'b0;
  logic [WW-1:0] dataZ_in = '0;
  logic [PW-1:0] memZ_addr_in = '0;
  logic          core_done_in = 1'b0;
  logic [WW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_in = 1'b0;
  logic          m_last_o;
  logic [PW-1:0] m_index_o;
  logic [PW:0]   result_len_o;
  logic          busy_o;
  logic          done_o;
  logic          overrun_o;

  conv_result_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rstn(rstn),
    .writeZ_in(writeZ_in), .dataZ_in(dataZ_in), .memZ_addr_in(memZ_addr_in),
    .core_done_in(core_done_in),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_in(m_ready_in),
    .m_last_o(m_last_o), .m_index_o(m_index_o), .result_len_o(result_len_o),
    .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model. Phases: 0 idle, 1 capture, 2 stream, 3 finish, 4 prefetch.
  int            m_phase = 0;
  int            m_len = 0;
  int            m_idx = 0;
  bit            m_ovr = 1'b0;
  logic [WW-1:0] m_mem [64];
  bit            m_known [64];
  bit            chk_en = 1'b0;

  logic [WW-1:0] acc_data [$];
  int            acc_idx [$];
  bit            acc_last [$];
  int            done_cnt = 0;
  int            done_seen_cyc = 0;
  int            last_acc_cyc = 0;
  int            first_valid_cyc = 0;
  int            done_drive_cyc = 0;
  bit            prev_valid = 1'b0;

  initial begin
    for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
  end

  always @(negedge clk) begin
    bit st;
    int nxt;
    int a;
    if (done_o) begin
      done_cnt++;
      done_seen_cyc = cyc;
    end
    if (m_valid_o && !prev_valid) first_valid_cyc = cyc;
    prev_valid = m_valid_o;
    if (chk_en) begin
      st = (m_phase == 2);
      chk("valid", m_valid_o, st);
      chk("busy", busy_o, (m_phase == 1) || (m_phase == 2) || (m_phase == 4));
      chk("done", done_o, m_phase == 3);
      chk("result_len", result_len_o, m_len);
      chk("overrun", overrun_o, m_ovr);
      if (st) begin
        chk("index", m_index_o, m_idx);
        chk("last", m_last_o, m_idx == m_len - 1);
        if (m_known[m_idx]) chk("data", m_data_o, m_mem[m_idx]);
      end else begin
        chk("last_when_idle", m_last_o, 0);
      end
      if (!rstn) begin
        m_phase = 0;
        m_len   = 0;
        m_idx   = 0;
        m_ovr   = 1'b0;
      end else begin
        nxt = m_phase;
        if (m_phase == 3) begin
          nxt = 0;
        end else if (m_phase == 4) begin
          nxt   = 2;
          m_idx = 0;
        end else if (m_phase == 2 && m_ready_in) begin
          acc_data.push_back(m_data_o);
          acc_idx.push_back(int'(m_index_o));
          acc_last.push_back(m_last_o);
          last_acc_cyc = cyc;
          $display("beat index=%0d data=0x%04h last=%0d", m_index_o, m_data_o, m_last_o);
          if (m_idx == m_len - 1) nxt = 3;
          else m_idx++;
        end
        if (writeZ_in) begin
          a = int'(memZ_addr_in);
          if (m_phase <= 1) begin
            m_mem[a]   = dataZ_in;
            m_known[a] = 1'b1;
            if (m_phase == 0 || a + 1 > m_len) m_len = a + 1;
            nxt = 1;
          end else if (m_phase == 2 || m_phase == 4) begin
            m_ovr = 1'b1;
          end
        end
        if (core_done_in) begin
          if (m_phase == 0 && !writeZ_in) nxt = 3;
          else if (m_phase <= 1) nxt = 4;
        end
        m_phase = nxt;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    writeZ_in    = 1'b1;
    memZ_addr_in = PW'(a);
    dataZ_in     = WW'(d);
    tick();
    writeZ_in = 1'b0;
  endtask

  task automatic clear_acc();
    acc_data.delete();
    acc_idx.delete();
    acc_last.delete();
  endtask

  task automatic pulse_done();
    core_done_in   = 1'b1;
    done_drive_cyc = cyc;
    tick();
    core_done_in = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, input bit bp);
    int start;
    int k;
    start = done_cnt;
    k = 0;
    while (done_cnt == start && k < budget) begin
      if (bp) m_ready_in = (k % 4 == 0) || (k % 4 == 3);
      tick();
      k++;
    end
    chk({name, "_timeout"}, done_cnt == start, 0);
    m_ready_in = 1'b1;
  endtask

  task automatic check_seq(input string name, input int n, input int base);
    chk({name, "_count"}, acc_data.size(), n);
    if (acc_data.size() == n) begin
      for (int i = 0; i < n; i++) begin
        chk({name, "_data"}, acc_data[i], (base + i) & 16'hFFFF);
        chk({name, "_idx"}, acc_idx[i], i);
        chk({name, "_last"}, acc_last[i], i == n - 1);
      end
    end
  endtask

  initial begin
    int saved;
    int k;
    repeat (3) tick();
    chk("rst_valid", m_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_overrun", overrun_o, 0);
    chk("rst_len", result_len_o, 0);
    chk("rst_data", m_data_o, 0);
    chk("rst_index", m_index_o, 0);
    chk("rst_last", m_last_o, 0);
    rstn = 1'b1;
    chk_en = 1'b1;
    tick();

    // Basic stream
    m_ready_in = 1'b1;
    for (int i = 0; i < 5; i++) wr(i, i + 1);
    chk("basic_len", result_len_o, 5);
    clear_acc();
    pulse_done();
    wait_done("basic", 50, 1'b0);
    check_seq("basic", 5, 1);
    chk("basic_latency", first_valid_cyc - done_drive_cyc, 2);
    chk("basic_done_timing", done_seen_cyc - last_acc_cyc, 1);
    tick();

    // Backpressure
    for (int i = 0; i < 5; i++) wr(i, i + 1);
    clear_acc();
    pulse_done();
    wait_done("backpressure", 80, 1'b1);
    check_seq("backpressure", 5, 1);
    tick();

    // Out-of-order and overwrite
    wr(3, 16'hAAAA);
    wr(0, 16'h1111);
    wr(3, 16'hBBBB);
    chk("ooo_len", result_len_o, 4);
    clear_acc();
    pulse_done();
    wait_done("ooo", 50, 1'b0);
    chk("ooo_count", acc_data.size(), 4);
    if (acc_data.size() == 4) begin
      chk("ooo_beat0", acc_data[0], 16'h1111);
      chk("ooo_beat3", acc_data[3], 16'hBBBB);
      chk("ooo_idx3", acc_idx[3], 3);
      chk("ooo_last3", acc_last[3], 1);
    end
    tick();

    // Boundary: address 63
    wr(63, 16'hC0DE);
    chk("bound_len", result_len_o, 64);
    clear_acc();
    pulse_done();
    wait_done("bound", 200, 1'b0);
    chk("bound_count", acc_data.size(), 64);
    if (acc_data.size() == 64) begin
      chk("bound_data63", acc_data[63], 16'hC0DE);
      chk("bound_idx63", acc_idx[63], 63);
      chk("bound_last63", acc_last[63], 1);
      chk("bound_last62", acc_last[62], 0);
    end
    tick();

    // Write and done in the same cycle
    wr(0, 16'h1234);
    writeZ_in    = 1'b1;
    memZ_addr_in = PW'(1);
    dataZ_in     = 16'h5678;
    clear_acc();
    pulse_done();
    writeZ_in = 1'b0;
    chk("wd_len", result_len_o, 2);
    wait_done("wd", 50, 1'b0);
    chk("wd_count", acc_data.size(), 2);
    if (acc_data.size() == 2) begin
      chk("wd_beat0", acc_data[0], 16'h1234);
      chk("wd_beat1", acc_data[1], 16'h5678);
    end
    tick();

    // Zero-length: done with no writes
    clear_acc();
    saved = done_cnt;
    pulse_done();
    wait_done("zero", 20, 1'b0);
    chk("zero_count", acc_data.size(), 0);
    chk("zero_done_pulses", done_cnt - saved, 1);
    tick();

    // Write during STREAM sets overrun and leaves data unchanged
    for (int i = 0; i < 5; i++) wr(i, 16'h10 + i);
    m_ready_in = 1'b0;
    clear_acc();
    pulse_done();
    k = 0;
    while (!m_valid_o && k < 10) begin
      tick();
      k++;
    end
    chk("ovr_valid_seen", m_valid_o, 1);
    wr(2, 16'hDEAD);
    chk("ovr_flag", overrun_o, 1);
    m_ready_in = 1'b1;
    wait_done("ovr", 50, 1'b0);
    check_seq("ovr", 5, 16'h10);
    tick();

    // Reset mid-stream
    for (int i = 0; i < 5; i++) wr(i, 16'h20 + i);
    clear_acc();
    pulse_done();
    k = 0;
    while (acc_data.size() < 2 && k < 20) begin
      tick();
      k++;
    end
    chk("rstmid_two_beats", acc_data.size() >= 2, 1);
    saved = done_cnt;
    rstn = 1'b0;
    tick();
    chk("rstmid_valid", m_valid_o, 0);
    chk("rstmid_busy", busy_o, 0);
    chk("rstmid_len", result_len_o, 0);
    chk("rstmid_overrun", overrun_o, 0);
    rstn = 1'b1;
    repeat (4) tick();
    chk("rstmid_no_done", done_cnt - saved, 0);

    // Fresh capture after reset
    for (int i = 0; i < 3; i++) wr(i, 16'h30 + i);
    chk("fresh_len", result_len_o, 3);
    clear_acc();
    pulse_done();
    wait_done("fresh", 50, 1'b0);
    check_seq("fresh", 3, 16'h30);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/conv_result_streamer.md
Name: conv_result_streamer

Overview:
- Downstream consumer of the convolution core's Z-write port (writeZ / dataZ / memZ_addr).
- Captures every result word the core produces into an internal result buffer and tracks the result length.
- After the core signals completion, streams the results in address order to the host-side interface over a valid/ready handshake, with a last-beat marker.
- Replaces the plain Z memory when the host reads results as a stream instead of by address.

Parameters:
- DATA_WIDTH, 8: operand width of the core; result word width is 2*DATA_WIDTH.
- ADDR_WIDTH, 5: operand address width of the core; the result address is ADDR_WIDTH+1 bits; buffer depth is 2^(ADDR_WIDTH+1) (64).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rstn  in  1  synchronous active-low reset.
- writeZ_in  in  1  core result write strobe.
- dataZ_in  in  2*DATA_WIDTH  core result word.
- memZ_addr_in  in  ADDR_WIDTH+1  core result address.
- core_done_in  in  1  core done pulse (one cycle).
- m_data_o  out  2*DATA_WIDTH  streamed result word.
- m_valid_o  out  1  m_data_o is valid.
- m_ready_in  in  1  downstream accepts the beat.
- m_last_o  out  1  current beat is the final result.
- m_index_o  out  ADDR_WIDTH+1  address of the current beat.
- result_len_o  out  ADDR_WIDTH+2  number of results captured.
- busy_o  out  1  capturing or streaming.
- done_o  out  1  one-cycle pulse after the last beat is accepted.
- overrun_o  out  1  sticky flag: a Z write arrived while streaming.

Behaviour:
- Reset (rstn=0 sampled at a rising edge):
  - FSM goes to IDLE.
  - m_valid_o, m_last_o, busy_o, done_o, overrun_o = 0.
  - m_data_o, m_index_o, result_len_o = 0.
  - Buffer contents are not cleared.
  - A reset mid-stream aborts the stream immediately; no done_o pulse is generated.
- Buffer: single-port-write, synchronous-read RAM with 1-cycle read latency.
- FSM states: IDLE, CAPTURE, PREFETCH, STREAM, FINISH.
- IDLE:
  - busy_o=0.
  - On writeZ_in=1: store the word, set result_len_o = memZ_addr_in+1, go to CAPTURE, busy_o=1 from the next cycle.
  - On core_done_in=1 without any prior write: go to FINISH (zero-length result).
- CAPTURE:
  - Each writeZ_in=1 stores dataZ_in at memZ_addr_in.
  - result_len_o = max(result_len_o, memZ_addr_in+1), computed at ADDR_WIDTH+2 bits so address 63 gives 64 with no wrap.
  - Repeated writes to the same address: last write wins.
- Write and done in the same cycle (CAPTURE): the write is stored and counted, then go to PREFETCH.
- Zero length at done: if result_len_o==0 when core_done_in is seen, go to FINISH.
- PREFETCH: read address 0 presented; go to STREAM next cycle.
- STREAM:
  - m_valid_o=1.
  - m_data_o = buffer[ptr]; m_index_o = ptr; m_last_o = (ptr == result_len_o-1).
  - Read address presented = ptr+1 when m_valid_o & m_ready_in, else ptr. This gives zero-bubble back-to-back beats.
  - m_data_o and m_index_o hold stable while m_valid_o=1 and m_ready_in=0.
  - Accepted beat with m_last_o=1: go to FINISH; m_valid_o=0 next cycle.
- FINISH:
  - done_o=1 for exactly one cycle; busy_o=0.
  - Return to IDLE; result_len_o retains its value until the next capture begins.
- A new writeZ_in in IDLE after FINISH starts a fresh capture: result_len_o restarts from that write's address+1.
- writeZ_in during PREFETCH or STREAM: ignored (buffer unchanged) and overrun_o set; overrun_o clears only on reset.
- core_done_in outside IDLE and CAPTURE: ignored.
- Latency: first beat is valid 2 cycles after the core_done_in edge (done→PREFETCH→STREAM); throughput 1 beat/cycle with m_ready_in held high.

Test Plan:
- Basic stream: writes addr 0..4 = 0x0001..0x0005, done, ready=1 → result_len_o=5; beats 0x0001..0x0005 on consecutive cycles starting 2 cycles after done; m_last_o only on index 4; done_o one cycle after index 4 is accepted.
- Backpressure: same data, ready toggled 1,0,0,1,… → each beat held stable while ready=0; no beat dropped or duplicated; 5 accepted in order.
- Out-of-order and overwrite: writes addr 3=0xAAAA, 0=0x1111, 3=0xBBBB, done → result_len_o=4; beat index 3 = 0xBBBB; indices 1 and 2 are emitted (undefined data allowed).
- Boundary: a write at addr 63, then done → result_len_o=64 (not 0); 64 beats; m_last_o at index 63.
- Corner events: write and done in the same cycle stores and streams that word; done with no writes → done_o pulses with no valid beat; write during STREAM → overrun_o=1 and streamed data unchanged.
- Reset mid-stream: rstn=0 after 2 accepted beats → next cycle m_valid_o=0, busy_o=0, result_len_o=0, no done_o; a fresh capture afterward works normally.
